mem_arbiter: RTL

Shares the single memory port between instruction fetch and the data cache. Picks one requester per cycle and forwards its command to memory. Records which requester owns each accepted load tag, and routes returning data back by tag. Fetch requests live across a squash are dropped when their data returns. Sits between `fetch` / `dcache` and the memory interface; `fetch_grant` drives fetch's `arbiter_signal`.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_tag_table.sv | 68 ++++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the memory-port arbiter and its load-tag table.
package mem_arbiter_pkg;

    localparam int NUM_MEM_TAGS  = 15;
    localparam int STARVE_LIMIT  = 4;
    localparam int FETCH_MAX_OUT = 8;

    localparam int TAG_W    = $clog2(NUM_MEM_TAGS + 1);
    localparam int OUT_W    = $clog2(NUM_MEM_TAGS + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int ADDR_W   = 32;
    localparam int BLOCK_W  = 64;

    typedef logic [TAG_W-1:0]   mem_tag_t;
    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [BLOCK_W-1:0] mem_block_t;

    typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} mem_command_e;
    typedef enum logic [1:0] {BR_NONE, BR_PREDICT, SQUASH} br_task_e;
    typedef enum logic {OWN_FETCH, OWN_DCACHE} mem_owner_e;

    typedef struct packed {
        logic       valid;
        mem_owner_e owner;
        logic       stale;
    } mem_tag_entry_t;

    function automatic logic is_live_fetch(input mem_tag_entry_t e);
        return e.valid && (e.owner == OWN_FETCH);
    endfunction

endpackage

// File: rtl/mem_tag_table.sv
// Per-tag ownership table for accepted loads, with squash marking and a
// running count of fetch-owned entries (stale ones included).
module mem_tag_table
    import mem_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    input  mem_tag_t         alloc_tag,
    input  mem_owner_e       alloc_owner,
    input  mem_tag_t         free_tag,
    input  logic             squash,
    output logic             lookup_valid,
    output mem_owner_e       lookup_owner,
    output logic             lookup_stale,
    output logic [OUT_W-1:0] fetch_outstanding
);

    mem_tag_entry_t [NUM_MEM_TAGS:1] entries_reg;
    mem_tag_entry_t [NUM_MEM_TAGS:1] entries_next;
    mem_tag_entry_t                  lookup_entry;
    logic [OUT_W-1:0]                count_reg;
    logic [OUT_W-1:0]                count_next;
    logic                            alloc_fetch;
    logic                            free_fetch;

    // Priority per entry: new allocation beats the return clear, which beats squash.
    genvar gi;
    generate
        for (gi = 1; gi <= NUM_MEM_TAGS; gi++) begin : g_entry
            assign entries_next[gi] =
                (alloc_en && alloc_tag == TAG_W'(gi)) ? mem_tag_entry_t'{valid: 1'b1, owner: alloc_owner, stale: 1'b0} :
                (free_tag == TAG_W'(gi))              ? mem_tag_entry_t'('0) :
                (squash && is_live_fetch(entries_reg[gi]))
                    ? mem_tag_entry_t'{valid: 1'b1, owner: OWN_FETCH, stale: 1'b1} :
                entries_reg[gi];
        end
    endgenerate

    always_comb begin
        lookup_entry = '0;
        if (free_tag != '0) begin
            lookup_entry = entries_reg[free_tag];
        end
    end

    assign lookup_valid = lookup_entry.valid;
    assign lookup_owner = lookup_entry.owner;
    // A squash landing in the return cycle already suppresses that fetch return.
    assign lookup_stale = lookup_entry.stale || (squash && lookup_entry.owner == OWN_FETCH);

    assign alloc_fetch = alloc_en && (alloc_owner == OWN_FETCH);
    assign free_fetch  = is_live_fetch(lookup_entry);
    assign count_next  = count_reg + OUT_W'(alloc_fetch) - OUT_W'(free_fetch);

    always_ff @(posedge clock) begin
        if (!reset) begin
            entries_reg <= '0;
            count_reg   <= '0;
        end else begin
            entries_reg <= entries_next;
            count_reg   <= count_next;
        end
    end

    assign fetch_outstanding = count_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between fetch and dcache, tracks load-tag
// ownership and routes returning data tags back to the right requester.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  br_task_e         br_task,
    input  logic             fetch_req,
    input  addr_t            fetch_addr,
    input  logic             dc_req,
    input  mem_command_e     dc_command,
    input  addr_t            dc_addr,
    input  mem_block_t       dc_data,
    input  mem_tag_t         mem2proc_transaction_tag,
    input  mem_tag_t         mem2proc_data_tag,
    input  mem_block_t       mem2proc_data,
    output mem_command_e     proc2mem_command,
    output addr_t            proc2mem_addr,
    output mem_block_t       proc2mem_data,
    output logic             fetch_grant,
    output mem_tag_t         fetch_tag,
    output logic             dc_grant,
    output mem_tag_t         dc_tag,
    output mem_tag_t         fetch_data_tag,
    output mem_tag_t         dc_data_tag,
    output mem_block_t       rsp_data,
    output logic [OUT_W-1:0] fetch_outstanding
);

    logic [STARVE_W-1:0] starve_cnt_reg;
    logic [STARVE_W-1:0] starve_cnt_next;
    logic                squash;
    logic                fetch_elig;
    logic                accepted;
    logic                fetch_accept;
    logic                alloc_en;
    mem_owner_e          alloc_owner;
    logic                lookup_valid;
    mem_owner_e          lookup_owner;
    logic                lookup_stale;
    logic                return_hit;

    assign squash     = (br_task == SQUASH);
    assign fetch_elig = fetch_req && (fetch_outstanding < OUT_W'(FETCH_MAX_OUT)) && !squash;

    always_comb begin
        fetch_grant      = 1'b0;
        dc_grant         = 1'b0;
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        fetch_tag        = '0;
        dc_tag           = '0;
        fetch_data_tag   = '0;
        dc_data_tag      = '0;
        if (reset) begin
            if (fetch_elig && dc_req) begin
                fetch_grant = (starve_cnt_reg == STARVE_W'(STARVE_LIMIT));
                dc_grant    = !fetch_grant;
            end else begin
                fetch_grant = fetch_elig;
                dc_grant    = dc_req;
            end
            if (fetch_grant) begin
                proc2mem_command = MEM_LOAD;
                proc2mem_addr    = fetch_addr;
                fetch_tag        = mem2proc_transaction_tag;
            end else if (dc_grant) begin
                proc2mem_command = dc_command;
                proc2mem_addr    = dc_addr;
                proc2mem_data    = dc_data;
                dc_tag           = mem2proc_transaction_tag;
            end
            if (return_hit && lookup_owner == OWN_FETCH) begin
                fetch_data_tag = mem2proc_data_tag;
            end else if (return_hit) begin
                dc_data_tag = mem2proc_data_tag;
            end
        end
    end

    assign return_hit   = lookup_valid && !lookup_stale;
    assign accepted     = (fetch_grant || dc_grant) && (mem2proc_transaction_tag != '0);
    assign fetch_accept = accepted && fetch_grant;
    // Stores never return data, so only loads claim a table entry.
    assign alloc_en     = accepted && (fetch_grant || dc_command == MEM_LOAD);
    assign alloc_owner  = fetch_grant ? OWN_FETCH : OWN_DCACHE;
    assign rsp_data     = mem2proc_data;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!fetch_req || fetch_accept) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    mem_tag_table u_tag_table (
        .clock             (clock),
        .reset             (reset),
        .alloc_en          (alloc_en),
        .alloc_tag         (mem2proc_transaction_tag),
        .alloc_owner       (alloc_owner),
        .free_tag          (mem2proc_data_tag),
        .squash            (squash),
        .lookup_valid      (lookup_valid),
        .lookup_owner      (lookup_owner),
        .lookup_stale      (lookup_stale),
        .fetch_outstanding (fetch_outstanding)
    );

endmodule
